// File: rtl/ppg_pkg.sv
// Shared definitions for the PPG LED/PGA controller and the AC/DC extractor.
// Contents: FSM state encoding, default window size, min/max tracker
// start values.
package ppg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REPORT  = 2'd2
  } ppg_state_t;

  localparam int PPG_WIN_LOG2_DEF = 6;

  // The min tracker starts at the top of the range and the max tracker at
  // the bottom, so the first accepted sample always replaces both.
  localparam logic [7:0] PPG_MIN_INIT = 8'hFF;
  localparam logic [7:0] PPG_MAX_INIT = 8'h00;

endpackage

// File: rtl/ppg_acdc_extractor_channel_acc.sv
// ppg_channel_acc: per-channel window accumulator (min, max, sum, count).
// Ports:
//   CLK, rst      clock and asynchronous active-high reset
//   clear         restart the window (priority over sample_en)
//   sample_en     sample event for this channel
//   sample        8-bit ADC value captured on sample_en
//   full          window holds 2^WIN_LOG2 samples; further events are dropped
//   ac            max - min of the window
//   dc            window mean (sum >> WIN_LOG2, truncating)
module ppg_channel_acc
  import ppg_pkg::*;
#(
  parameter int WIN_LOG2 = PPG_WIN_LOG2_DEF
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       clear,
  input  logic       sample_en,
  input  logic [7:0] sample,
  output logic       full,
  output logic [7:0] ac,
  output logic [7:0] dc
);

  localparam logic [WIN_LOG2:0] WIN_N = {1'b1, {WIN_LOG2{1'b0}}};

  logic [WIN_LOG2:0]   count;
  logic [WIN_LOG2+7:0] sum;
  logic [7:0]          min_v;
  logic [7:0]          max_v;

  assign full = (count == WIN_N);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      count <= '0;
      sum   <= '0;
      min_v <= PPG_MIN_INIT;
      max_v <= PPG_MAX_INIT;
    end else if (clear) begin
      count <= '0;
      sum   <= '0;
      min_v <= PPG_MIN_INIT;
      max_v <= PPG_MAX_INIT;
    end else if (sample_en && !full) begin
      if (sample < min_v) min_v <= sample;
      if (sample > max_v) max_v <= sample;
      sum   <= sum + {{WIN_LOG2{1'b0}}, sample};
      count <= count + {{WIN_LOG2{1'b0}}, 1'b1};
    end
  end

  // Only read once the window is full, when max >= min always holds.
  assign ac = max_v - min_v;
  assign dc = 8'(sum >> WIN_LOG2);

endmodule

// File: rtl/ppg_acdc_extractor.sv
// ppg_acdc_extractor: windowed AC (max-min) and DC (mean) extraction of the
// red and IR PPG channels. A sample is taken on the falling edge of each LED
// phase signal.
// Ports:
//   CLK, rst                      clock, asynchronous active-high reset
//   Setting_Done                  controller is in operation mode
//   LED_RED, LED_IR               LED phase signals
//   RED_ADC_Value, IR_ADC_Value   latest ADC samples
//   RED_AC/RED_DC/IR_AC/IR_DC     window results, held between updates
//   Result_Valid                  one-cycle pulse when results update
//   Busy                          high while collecting
//   LED_Fault                     sticky: both LEDs seen on while collecting
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | controller not in operation mode; accumulators held clear
// COLLECT | accepting sample events until both channels are full
// REPORT  | one cycle: latch results, pulse Result_Valid, restart window
module ppg_acdc_extractor
  import ppg_pkg::*;
#(
  parameter int WIN_LOG2 = PPG_WIN_LOG2_DEF
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       Setting_Done,
  input  logic       LED_RED,
  input  logic       LED_IR,
  input  logic [7:0] RED_ADC_Value,
  input  logic [7:0] IR_ADC_Value,
  output logic [7:0] RED_AC,
  output logic [7:0] RED_DC,
  output logic [7:0] IR_AC,
  output logic [7:0] IR_DC,
  output logic       Result_Valid,
  output logic       Busy,
  output logic       LED_Fault
);

  ppg_state_t state;

  logic led_red_q;
  logic led_ir_q;
  logic red_evt;
  logic ir_evt;
  logic led_conflict;
  logic acc_take;
  logic acc_clear;
  logic red_full;
  logic ir_full;
  logic [7:0] red_ac;
  logic [7:0] red_dc;
  logic [7:0] ir_ac;
  logic [7:0] ir_dc;

  // History starts at 0, so an LED already high at reset release can only
  // produce an event after it has been seen high for a full cycle.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      led_red_q <= 1'b0;
      led_ir_q  <= 1'b0;
    end else begin
      led_red_q <= LED_RED;
      led_ir_q  <= LED_IR;
    end
  end

  assign red_evt      = led_red_q & ~LED_RED;
  assign ir_evt       = led_ir_q & ~LED_IR;
  assign led_conflict = LED_RED & LED_IR;

  // A conflict cycle both restarts the window and blocks that cycle's events.
  assign acc_take  = (state == ST_COLLECT) && Setting_Done && !led_conflict;
  assign acc_clear = (state != ST_COLLECT) || !Setting_Done || led_conflict;

  ppg_channel_acc #(.WIN_LOG2(WIN_LOG2)) u_red_acc (
    .CLK       (CLK),
    .rst       (rst),
    .clear     (acc_clear),
    .sample_en (acc_take & red_evt),
    .sample    (RED_ADC_Value),
    .full      (red_full),
    .ac        (red_ac),
    .dc        (red_dc)
  );

  ppg_channel_acc #(.WIN_LOG2(WIN_LOG2)) u_ir_acc (
    .CLK       (CLK),
    .rst       (rst),
    .clear     (acc_clear),
    .sample_en (acc_take & ir_evt),
    .sample    (IR_ADC_Value),
    .full      (ir_full),
    .ac        (ir_ac),
    .dc        (ir_dc)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      RED_AC       <= '0;
      RED_DC       <= '0;
      IR_AC        <= '0;
      IR_DC        <= '0;
      Result_Valid <= 1'b0;
      LED_Fault    <= 1'b0;
    end else begin
      Result_Valid <= 1'b0;
      if ((state == ST_COLLECT) && Setting_Done && led_conflict) LED_Fault <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (Setting_Done) state <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (!Setting_Done)              state <= ST_IDLE;
          else if (led_conflict)          state <= ST_COLLECT;
          else if (red_full && ir_full)   state <= ST_REPORT;
        end
        ST_REPORT: begin
          if (!Setting_Done) begin
            state <= ST_IDLE;
          end else begin
            RED_AC       <= red_ac;
            RED_DC       <= red_dc;
            IR_AC        <= ir_ac;
            IR_DC        <= ir_dc;
            Result_Valid <= 1'b1;
            state        <= ST_COLLECT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy = (state == ST_COLLECT);

endmodule

// File: tb/tb_ppg_acdc_extractor.sv
// Scoreboard bench for ppg_acdc_extractor: each stimulus window pushes its
// hand-computed results; the monitor pops and compares on every Result_Valid.
module tb_ppg_acdc_extractor;

  logic       CLK = 1'b0;
  logic       rst;
  logic       Setting_Done;
  logic       LED_RED;
  logic       LED_IR;
  logic [7:0] RED_ADC_Value;
  logic [7:0] IR_ADC_Value;
  logic [7:0] RED_AC;
  logic [7:0] RED_DC;
  logic [7:0] IR_AC;
  logic [7:0] IR_DC;
  logic       Result_Valid;
  logic       Busy;
  logic       LED_Fault;

  typedef struct {
    logic [7:0] rac;
    logic [7:0] rdc;
    logic [7:0] iac;
    logic [7:0] idc;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  ppg_acdc_extractor dut (
    .CLK           (CLK),
    .rst           (rst),
    .Setting_Done  (Setting_Done),
    .LED_RED       (LED_RED),
    .LED_IR        (LED_IR),
    .RED_ADC_Value (RED_ADC_Value),
    .IR_ADC_Value  (IR_ADC_Value),
    .RED_AC        (RED_AC),
    .RED_DC        (RED_DC),
    .IR_AC         (IR_AC),
    .IR_DC         (IR_DC),
    .Result_Valid  (Result_Valid),
    .Busy          (Busy),
    .LED_Fault     (LED_Fault)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: compare every result pulse against the oldest expectation.
  always @(negedge CLK) begin
    if (!rst && Result_Valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result_valid: got 1 expected 0 at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("red_ac", RED_AC, e.rac);
        check("red_dc", RED_DC, e.rdc);
        check("ir_ac",  IR_AC,  e.iac);
        check("ir_dc",  IR_DC,  e.idc);
      end
    end
  end

  // One LED phase pair; the trailing idle cycles keep the next event clear
  // of the REPORT cycle.
  task automatic phase(input logic [7:0] r, input logic [7:0] i, input bit do_r, input bit do_i);
    @(negedge CLK); RED_ADC_Value = r; IR_ADC_Value = i; LED_RED = do_r;
    @(negedge CLK); LED_RED = 1'b0;
    @(negedge CLK); LED_IR = do_i;
    @(negedge CLK); LED_IR = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic push(input logic [7:0] rac, input logic [7:0] rdc,
                      input logic [7:0] iac, input logic [7:0] idc);
    exp_t e;
    e.rac = rac; e.rdc = rdc; e.iac = iac; e.idc = idc;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge CLK);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; Setting_Done = 1'b0; LED_RED = 1'b0; LED_IR = 1'b0;
    RED_ADC_Value = '0; IR_ADC_Value = '0;

    @(negedge CLK);
    check("rst_red_ac", RED_AC, 8'd0);
    check("rst_red_dc", RED_DC, 8'd0);
    check("rst_ir_ac", IR_AC, 8'd0);
    check("rst_ir_dc", IR_DC, 8'd0);
    check("rst_valid", {7'd0, Result_Valid}, 8'd0);
    check("rst_busy", {7'd0, Busy}, 8'd0);
    check("rst_fault", {7'd0, LED_Fault}, 8'd0);

    rst = 1'b0;
    @(negedge CLK);
    check("idle_busy", {7'd0, Busy}, 8'd0);
    Setting_Done = 1'b1;
    @(negedge CLK);
    check("collect_busy", {7'd0, Busy}, 8'd1);

    // Ramp 100..163 on red, constant IR.
    push(8'd63, 8'd131, 8'd0, 8'd128);
    for (int k = 0; k < 64; k++) phase(8'(100 + k), 8'd128, 1'b1, 1'b1);
    wait_drain("ramp");

    // Full-scale extremes.
    push(8'd255, 8'd127, 8'd10, 8'd15);
    for (int k = 0; k < 64; k++)
      phase((k % 2) ? 8'd255 : 8'd0, (k % 2) ? 8'd20 : 8'd10, 1'b1, 1'b1);
    wait_drain("extremes");

    // 30 events then an LED conflict. Both LEDs falling together after the
    // conflict cycle is the first event of the new window.
    for (int k = 0; k < 30; k++) phase(8'd240, 8'd240, 1'b1, 1'b1);
    check("fault_pre", {7'd0, LED_Fault}, 8'd0);
    @(negedge CLK); RED_ADC_Value = 8'd50; IR_ADC_Value = 8'd0; LED_RED = 1'b1; LED_IR = 1'b1;
    @(negedge CLK); LED_RED = 1'b0; LED_IR = 1'b0;
    check("fault_set", {7'd0, LED_Fault}, 8'd1);
    @(negedge CLK);
    @(negedge CLK);
    check("fault_busy", {7'd0, Busy}, 8'd1);
    push(8'd0, 8'd50, 8'd63, 8'd31);
    for (int k = 1; k < 64; k++) phase(8'd50, 8'(k), 1'b1, 1'b1);
    wait_drain("fault");
    check("fault_sticky", {7'd0, LED_Fault}, 8'd1);

    // Operation mode dropped mid-window.
    for (int k = 0; k < 40; k++) phase(8'd1, 8'd1, 1'b1, 1'b1);
    @(negedge CLK); Setting_Done = 1'b0;
    @(negedge CLK);
    check("drop_busy", {7'd0, Busy}, 8'd0);
    @(negedge CLK);
    check("drop_hold_red_dc", RED_DC, 8'd50);
    check("drop_hold_ir_ac", IR_AC, 8'd63);
    Setting_Done = 1'b1;
    @(negedge CLK);
    check("resume_busy", {7'd0, Busy}, 8'd1);
    push(8'd0, 8'd200, 8'd3, 8'd11);
    for (int k = 0; k < 64; k++) phase(8'd200, 8'(10 + (k % 4)), 1'b1, 1'b1);
    wait_drain("resume");

    // Red overruns: 64 accepted (0..63), then 6 extra at 255 ignored.
    push(8'd63, 8'd31, 8'd0, 8'd5);
    for (int k = 0; k < 63; k++) phase(8'(k), 8'd5, 1'b1, 1'b1);
    phase(8'd63, 8'd5, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) phase(8'd255, 8'd5, 1'b1, 1'b0);
    phase(8'd255, 8'd5, 1'b0, 1'b1);
    wait_drain("overrun");

    // Reset in the middle of a window.
    for (int k = 0; k < 10; k++) phase(8'd77, 8'd77, 1'b1, 1'b1);
    check("pre_rst_busy", {7'd0, Busy}, 8'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_red_ac", RED_AC, 8'd0);
    check("mid_rst_red_dc", RED_DC, 8'd0);
    check("mid_rst_ir_dc", IR_DC, 8'd0);
    check("mid_rst_busy", {7'd0, Busy}, 8'd0);
    check("mid_rst_fault", {7'd0, LED_Fault}, 8'd0);
    @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ppg_acdc_extractor.md
PPG_ACDC_EXTRACTOR -- requirements
Module: ppg_acdc_extractor

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 6, log2 of samples per channel per window (window = 64).
REQ-002 SHALL have ports: CLK  in  1  system clock, all state on rising edge; one clock, no other clock domain.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: Setting_Done  in  1  level, high while the LED/PGA controller is in operation mode.
REQ-005 SHALL have ports: LED_RED, LED_IR  in  1 each  LED phase signals from the controller.
REQ-006 SHALL have ports: RED_ADC_Value, IR_ADC_Value  in  8 each  latest per-channel ADC samples from the controller.
REQ-007 SHALL have ports: RED_AC, RED_DC, IR_AC, IR_DC  out  8 each  window results (AC = max-min, DC = mean).
REQ-008 SHALL have ports: Result_Valid  out  1  one-cycle pulse when the four results update.
REQ-009 SHALL have ports: Busy  out  1  high in COLLECT; LED_Fault  out  1  sticky LED-conflict flag.

Function
REQ-010 SHALL implement FSM states IDLE, COLLECT, REPORT.
REQ-011 IDLE SHALL move to COLLECT on the first cycle Setting_Done is high, clearing counters, sums, min (255) and max (0).
REQ-012 SHALL register LED_RED and LED_IR each cycle; a red sample event is LED_RED previous 1, current 0; an IR sample event is LED_IR previous 1, current 0.
REQ-013 On a red event in COLLECT with red count < 2^WIN_LOG2, SHALL capture RED_ADC_Value: update red min, max, add to red sum, increment red count; IR identical on IR events.
REQ-014 Red and IR events in the same cycle SHALL both be accepted independently.
REQ-015 Events for a channel whose count has reached 2^WIN_LOG2 SHALL be discarded.
REQ-016 Sums SHALL be 8+WIN_LOG2 bits wide, no overflow possible; counts WIN_LOG2+1 bits.
REQ-017 When both counts equal 2^WIN_LOG2, SHALL go to REPORT on the next edge.
REQ-018 In REPORT (one cycle): AC outputs = max-min (8-bit, never negative), DC outputs = sum >> WIN_LOG2 (truncating); Result_Valid high that cycle; next state COLLECT with accumulators cleared.
REQ-019 Result outputs SHALL hold their values between REPORT cycles.
REQ-020 A sample of value 0 or 255 SHALL be processed normally (min/max reach bounds).
REQ-021 If LED_RED and LED_IR are both high during COLLECT, SHALL set LED_Fault, discard the current window (clear accumulators) and stay in COLLECT; no event is taken that cycle.
REQ-022 LED_Fault SHALL clear only on reset.
REQ-023 Setting_Done low in COLLECT or REPORT SHALL return to IDLE next edge, discard the partial window, no Result_Valid; results hold.
REQ-024 Busy SHALL be high exactly in COLLECT.
REQ-025 Latency: Result_Valid SHALL assert 2 cycles after the edge on which the final (second channel's 64th) event is observed.

Reset
REQ-026 rst high SHALL immediately force IDLE, all outputs 0, counts/sums 0, min 255, max 0, LED history registers 0.
REQ-027 Reset release mid-LED-phase SHALL not generate a sample event (history starts at 0).

Structure
REQ-028 FSM state encodings, default WIN_LOG2 and min/max reset constants SHALL live in shared package ppg_pkg used by the controller and this block.
REQ-029 Per-channel min/max/sum/count logic SHALL be one sub-module, ppg_channel_acc, instantiated twice (red, IR).

Verification
REQ-030 Reset then Setting_Done=1, 64 alternating phases with red samples 100..163 and IR constant 128 -> Result_Valid once; RED_AC=63, RED_DC=131, IR_AC=0, IR_DC=128.
REQ-031 Red samples alternating 0/255, IR 10/20 -> RED_AC=255, RED_DC=127, IR_AC=10, IR_DC=15.
REQ-032 Both LEDs high for 1 cycle after 30 events -> LED_FAULT=1, no Result_Valid until 64 further events per channel.
REQ-033 Setting_Done dropped after 40 events, raised again -> Busy low 1+ cycles, no Result_Valid until 64 new events per channel; previous results unchanged.
REQ-034 Red channel receives 70 events before IR reaches 64 -> extra 6 ignored; RED_DC matches mean of first 64 only.
REQ-035 rst asserted during COLLECT -> all outputs 0 same cycle, state IDLE, LED_Fault 0.
